jk_bank: RTL and testbench

Parametrised bank of WIDTH JK flip-flops with synchronous reset, parallel load and a run-time mode select. The bank works as independent JK, T or D flops, or as a modulo-MOD up/down counter built from the same JK cells. It replaces single-bit JK flops wherever the design needs multi-bit registers, toggle banks or small counters.

---
 rtl/jk_pkg.sv | 35 +++
 rtl/jk_cell.sv | 55 +++++
 rtl/jk_bank.sv | 132 +++++++++++++
 tb/tb_jk_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pkg
// Description : Shared types and helpers for the JK flop bank: mode encoding
//               and the counter-mode per-bit toggle vector.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    // Widest bank the helper function supports
    localparam int c_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,
        MODE_T   = 2'b01,
        MODE_D   = 2'b10,
        MODE_CNT = 2'b11
    } mode_e;

    // Ripple-carry toggle terms: bit i toggles when every lower bit equals
    // 1 (counting up) or 0 (counting down). Bit 0 always toggles.
    function automatic logic [c_MAX_WIDTH-1:0] cnt_toggle(
        input logic [c_MAX_WIDTH-1:0] cur,
        input logic                   up
    );
        logic [c_MAX_WIDTH-1:0] t;
        t[0] = 1'b1;
        for (int i = 1; i < c_MAX_WIDTH; i++) begin
            t[i] = t[i-1] & (cur[i-1] == up);
        end
        return t;
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : Single JK flip-flop with synchronous reset, parallel-load
//               override and clock enable. qbar is the registered bit inverted.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic load,
    input  logic d,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    // Next-state: load overrides the enable, then the JK truth table
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            case ({j, k})
                2'b00:   q_d = q_q;
                2'b01:   q_d = 1'b0;
                2'b10:   q_d = 1'b1;
                default: q_d = ~q_q;
            endcase
        end
    end

    // State register with synchronous reset taking top priority
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_bank.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank
// Description : Bank of WIDTH JK cells steered into JK, T, D or modulo-MOD
//               up/down counter behaviour by a run-time mode select.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank
    import jk_pkg::*;
#(
    parameter int                 WIDTH   = 4,
    parameter longint unsigned    MOD     = 64'd1 << WIDTH,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             wrap
);

    // Terminal count of the counter (MOD-1 always fits in WIDTH bits)
    localparam logic [WIDTH-1:0] c_MAX_CNT = WIDTH'(MOD - 64'd1);

    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] cell_qbar;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] cell_d;
    logic             cell_load;
    logic [WIDTH-1:0] tog;
    logic             at_top;
    logic             above_top;
    logic             at_zero;
    logic             wrap_q;
    logic             wrap_d;
    mode_e            mode_s;

    assign mode_s    = mode_e'(mode);
    assign tog       = WIDTH'(cnt_toggle(c_MAX_WIDTH'(cell_q), dir));
    // at_top covers q == MAX and any out-of-range value above it
    assign at_top    = (cell_q >= c_MAX_CNT);
    assign above_top = at_top && (cell_q != c_MAX_CNT);
    assign at_zero   = (cell_q == '0);

    // Mode steering: map each mode onto J/K terms; counter wrap/clamp uses the load path
    always_comb begin
        cell_j    = j;
        cell_k    = k;
        cell_load = load;
        cell_d    = load_val;
        wrap_d    = 1'b0;
        if (!load && en) begin
            case (mode_s)
                MODE_JK: begin
                    cell_j = j;
                    cell_k = k;
                end
                MODE_T: begin
                    cell_j = j;
                    cell_k = j;
                end
                MODE_D: begin
                    cell_j = j;
                    cell_k = ~j;
                end
                MODE_CNT: begin
                    cell_j = tog;
                    cell_k = tog;
                    if (dir) begin
                        if (at_top) begin
                            cell_load = 1'b1;
                            cell_d    = '0;
                            wrap_d    = 1'b1;
                        end
                    end else if (at_zero) begin
                        cell_load = 1'b1;
                        cell_d    = c_MAX_CNT;
                        wrap_d    = 1'b1;
                    end else if (above_top) begin
                        cell_load = 1'b1;
                        cell_d    = c_MAX_CNT;
                    end
                end
                default: begin
                    cell_j = j;
                    cell_k = k;
                end
            endcase
        end
    end

    // Wrap pulse register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cells
            jk_cell #(
                .RST_BIT (RST_VAL[i])
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .j    (cell_j[i]),
                .k    (cell_k[i]),
                .load (cell_load),
                .d    (cell_d[i]),
                .q    (cell_q[i]),
                .qbar (cell_qbar[i])
            );
        end
    endgenerate

    assign q    = cell_q;
    assign qbar = cell_qbar;
    assign wrap = wrap_q;

endmodule : jk_bank
`default_nettype wire

// File: tb/tb_jk_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank
// Description : Scoreboard bench for jk_bank (WIDTH=4, MOD=10, RST_VAL=1010).
//               The driver pushes behavioural-model results; a monitor pops
//               and compares after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank;

    localparam int         c_W   = 4;
    localparam int         c_MOD = 10;
    localparam logic [3:0] c_RST = 4'b1010;

    localparam logic [1:0] c_JK  = 2'b00;
    localparam logic [1:0] c_T   = 2'b01;
    localparam logic [1:0] c_D   = 2'b10;
    localparam logic [1:0] c_CNT = 2'b11;

    logic           clk;
    logic           rst;
    logic           en;
    logic [1:0]     mode;
    logic [c_W-1:0] j;
    logic [c_W-1:0] k;
    logic           dir;
    logic           load;
    logic [c_W-1:0] load_val;
    logic [c_W-1:0] q;
    logic [c_W-1:0] qbar;
    logic           wrap;

    typedef struct packed {
        logic [c_W-1:0] q;
        logic           wrap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int   m_q = 0;
    logic m_w = 1'b0;

    jk_bank #(
        .WIDTH   (c_W),
        .MOD     (c_MOD),
        .RST_VAL (c_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .j        (j),
        .k        (k),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .qbar     (qbar),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one result per edge, compared #1 after the edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("q", q, mon_e.q);
            check("qbar", qbar, ~mon_e.q);
            check("wrap", {3'b000, wrap}, {3'b000, mon_e.wrap});
        end
    end

    // Apply one cycle of stimulus and push the model's post-edge state
    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [3:0] jj, input logic [3:0] kk,
                         input logic d, input logic ld, input logic [3:0] lv);
        logic [3:0] bits;
        exp_t       x;
        @(negedge clk);
        rst = r; en = e; mode = m; j = jj; k = kk; dir = d; load = ld; load_val = lv;
        if (r) begin
            m_q = int'(c_RST);
            m_w = 1'b0;
        end else if (ld) begin
            m_q = int'(lv);
            m_w = 1'b0;
        end else if (!e) begin
            m_w = 1'b0;
        end else begin
            m_w  = 1'b0;
            bits = 4'(m_q);
            case (m)
                c_JK: begin
                    for (int i = 0; i < c_W; i++) begin
                        if (jj[i] && kk[i])  bits[i] = ~bits[i];
                        else if (jj[i])      bits[i] = 1'b1;
                        else if (kk[i])      bits[i] = 1'b0;
                    end
                    m_q = int'(bits);
                end
                c_T: m_q = int'(bits ^ jj);
                c_D: m_q = int'(jj);
                default: begin
                    if (d) begin
                        if (m_q >= c_MOD - 1) begin
                            m_q = 0;
                            m_w = 1'b1;
                        end else begin
                            m_q = m_q + 1;
                        end
                    end else begin
                        if (m_q == 0) begin
                            m_q = c_MOD - 1;
                            m_w = 1'b1;
                        end else if (m_q > c_MOD - 1) begin
                            m_q = c_MOD - 1;
                        end else begin
                            m_q = m_q - 1;
                        end
                    end
                end
            endcase
        end
        x.q    = 4'(m_q);
        x.wrap = m_w;
        sb.push_back(x);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = c_JK; j = '0; k = '0;
        dir = 1'b0; load = 1'b0; load_val = '0;

        // Reset with JK inputs all high and enable on
        drive(1, 1, c_JK, 4'hF, 4'hF, 0, 0, 4'h0);
        // JK mode from zero
        drive(0, 1, c_JK, 4'h0, 4'h0, 0, 1, 4'h0);
        drive(0, 1, c_JK, 4'b0011, 4'b0101, 0, 0, 4'h0);
        drive(0, 1, c_JK, 4'hF, 4'hF, 0, 0, 4'h0);
        // T mode toggling bit 0, then hold with enable low
        drive(0, 1, c_T, 4'h0, 4'h0, 0, 1, 4'h0);
        repeat (4) drive(0, 1, c_T, 4'b0001, 4'h0, 0, 0, 4'h0);
        repeat (3) drive(0, 0, c_T, 4'b1111, 4'h0, 0, 0, 4'h0);
        // D mode
        drive(0, 1, c_D, 4'b0110, 4'h0, 0, 0, 4'h0);
        // Counter up through the wrap, then down from zero
        drive(0, 1, c_CNT, 4'h0, 4'h0, 1, 1, 4'h0);
        repeat (10) drive(0, 1, c_CNT, 4'h5, 4'hA, 1, 0, 4'h0);
        drive(0, 1, c_CNT, 4'h0, 4'h0, 0, 0, 4'h0);
        // Out-of-range value: up wraps, down clamps
        drive(0, 1, c_CNT, 4'h0, 4'h0, 1, 1, 4'd13);
        drive(0, 1, c_CNT, 4'h0, 4'h0, 1, 0, 4'h0);
        drive(0, 1, c_CNT, 4'h0, 4'h0, 0, 1, 4'd13);
        drive(0, 1, c_CNT, 4'h0, 4'h0, 0, 0, 4'h0);
        // Load at the wrap point wins over counting
        drive(0, 1, c_CNT, 4'h0, 4'h0, 1, 1, 4'd9);
        drive(0, 1, c_CNT, 4'h0, 4'h0, 1, 1, 4'd9);
        // Count to 5 then reset mid-count
        repeat (6) drive(0, 1, c_CNT, 4'h0, 4'h0, 1, 0, 4'h0);
        drive(1, 1, c_CNT, 4'h0, 4'h0, 1, 0, 4'h0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                  1'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom));
        end
        drive(0, 0, c_JK, 4'h0, 4'h0, 0, 0, 4'h0);

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_jk_bank
`default_nettype wire
